// File: rtl/prompt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prompt_sequencer
// Description : Timed lane-prompt generator. It alternates gap and show beats,
//               picks lanes from an 8-bit LFSR, scores hits and flags misses.
// Revision    : 1.0 - initial release
// ============================================================================
module prompt_sequencer #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned BEAT_CYCLES = 50,
    parameter int unsigned HOLD_BEATS  = 2,
    parameter int unsigned ROUND_LEN   = 16,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             EN,
    input  logic             HIT,
    output logic [LANES-1:0] LANE,
    output logic             VALID,
    output logic             MISS,
    output logic [7:0]       SCORE,
    output logic             DONE
);

    localparam int unsigned LW = $clog2(LANES);
    // One counter serves both the gap beat and the (longer) hit window.
    localparam int unsigned CW = $clog2(HOLD_BEATS * BEAT_CYCLES);

    localparam logic [CW-1:0]    c_GAP_LOAD  = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0]    c_WIN_LOAD  = CW'(HOLD_BEATS * BEAT_CYCLES - 1);
    localparam logic [CW-1:0]    c_CNT_ONE   = CW'(1);
    localparam logic [7:0]       c_ROUND_LEN = 8'(ROUND_LEN);
    localparam logic [7:0]       c_SEED      = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [LANES-1:0] c_LANE_ONE  = LANES'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GAP    = 2'd1;
    localparam logic [1:0] c_SHOW   = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_lfsr;
    logic [7:0]       r_count;
    logic [7:0]       w_lfsr_next;
    logic [LANES-1:0] w_onehot;

    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_onehot    = c_LANE_ONE << w_lfsr_next[LW-1:0];

    always_ff @(posedge C) begin
        if (CLR) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_lfsr  <= c_SEED;
            r_count <= '0;
            LANE    <= '0;
            VALID   <= 1'b0;
            MISS    <= 1'b0;
            SCORE   <= '0;
            DONE    <= 1'b0;
        end else begin
            MISS <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    LANE  <= '0;
                    VALID <= 1'b0;
                    DONE  <= 1'b0;
                    if (EN) begin
                        r_state <= c_GAP;
                        SCORE   <= '0;
                        r_count <= '0;
                        r_cnt   <= c_GAP_LOAD;
                    end
                end
                c_GAP: begin
                    if (!EN) begin
                        r_state <= c_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (r_count == c_ROUND_LEN) begin
                        r_state <= c_FINISH;
                        DONE    <= 1'b1;
                    end else begin
                        r_state <= c_SHOW;
                        r_lfsr  <= w_lfsr_next;
                        LANE    <= w_onehot;
                        VALID   <= 1'b1;
                        r_cnt   <= c_WIN_LOAD;
                    end
                end
                c_SHOW: begin
                    if (!EN) begin
                        r_state <= c_IDLE;
                        VALID   <= 1'b0;
                        LANE    <= '0;
                    end else if (HIT || (r_cnt == '0)) begin
                        // A hit on the expiry edge still counts as a hit.
                        if (HIT) begin
                            if (SCORE != 8'hFF) begin
                                SCORE <= SCORE + 8'd1;
                            end
                        end else begin
                            MISS <= 1'b1;
                        end
                        r_count <= r_count + 8'd1;
                        r_state <= c_GAP;
                        r_cnt   <= c_GAP_LOAD;
                        VALID   <= 1'b0;
                        LANE    <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_FINISH: begin
                    VALID <= 1'b0;
                    LANE  <= '0;
                    if (!EN) begin
                        r_state <= c_IDLE;
                        DONE    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prompt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prompt_sequencer
// Description : Self-checking bench for prompt_sequencer with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prompt_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic       hit = 1'b0;
    logic [3:0] lane;
    logic       valid;
    logic       miss;
    logic [7:0] score;
    logic       done;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] m_lfsr      = 8'hA5;

    always #5 clk = ~clk;

    prompt_sequencer #(
        .LANES      (4),
        .BEAT_CYCLES(4),
        .HOLD_BEATS (2),
        .ROUND_LEN  (3),
        .SEED       (8'hA5)
    ) dut (
        .C    (clk),
        .CLR  (clr),
        .EN   (en),
        .HIT  (hit),
        .LANE (lane),
        .VALID(valid),
        .MISS (miss),
        .SCORE(score),
        .DONE (done)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [3:0] lane_of(input logic [7:0] v);
        logic [3:0] one;
        one = 4'b0001;
        return one << v[1:0];
    endfunction

    // Packed view {VALID, LANE, MISS, SCORE, DONE}
    function automatic logic [14:0] obs();
        return {valid, lane, miss, score, done};
    endfunction

    function automatic logic [14:0] pack(input logic v, input logic [3:0] l, input logic m,
                                         input logic [7:0] s, input logic d);
        return {v, l, m, s, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b0; hit = 1'b0;
        tick(); tick();
        clr = 1'b0;
        m_lfsr = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs() !== 15'd0) begin
                miscompares++;
                $display("FAIL reset_idle c%0d: got %h expected %h", i, obs(), 15'd0);
            end
        end
    endtask

    task automatic test_hit_path();
        logic [14:0] e;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== 15'd0) begin
                miscompares++;
                $display("FAIL hit_first_gap c%0d: got %h expected %h", i, obs(), 15'd0);
            end
        end
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd0, 1'b0);
        vectors++;
        if (obs() !== e || lane !== 4'b0100) begin
            miscompares++;
            $display("FAIL hit_first_prompt: got %h expected %h", obs(), e);
        end
        tick();
        hit = 1'b1; tick(); hit = 1'b0;
        e = pack(1'b0, 4'b0000, 1'b0, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL hit_score: got %h expected %h", obs(), e);
        end
        tick(); tick(); tick();
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e || lane !== 4'b0010) begin
            miscompares++;
            $display("FAIL hit_second_prompt: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_miss_path();
        logic [14:0] e;
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL miss_window c%0d: got %h expected %h", i, obs(), e);
            end
        end
        tick();
        e = pack(1'b0, 4'b0000, 1'b1, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL miss_pulse: got %h expected %h", obs(), e);
        end
        tick();
        e = pack(1'b0, 4'b0000, 1'b0, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL miss_pulse_width: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_round_end();
        logic [14:0] e;
        tick(); tick();
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e || lane !== 4'b0100) begin
            miscompares++;
            $display("FAIL round_third_prompt: got %h expected %h", obs(), e);
        end
        tick();
        hit = 1'b1; tick(); hit = 1'b0;
        tick(); tick(); tick();
        e = pack(1'b0, 4'b0000, 1'b0, 8'd2, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL round_last_gap: got %h expected %h", obs(), e);
        end
        e = pack(1'b0, 4'b0000, 1'b0, 8'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL round_done_hold c%0d: got %h expected %h", i, obs(), e);
            end
        end
        en = 1'b0; tick();
        e = pack(1'b0, 4'b0000, 1'b0, 8'd2, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL round_done_release: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_simultaneous();
        logic [14:0] e;
        en = 1'b1;
        tick(); tick(); tick(); tick();
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        for (int i = 1; i < 8; i++) tick();
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd0, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL simul_window_open: got %h expected %h", obs(), e);
        end
        hit = 1'b1; tick(); hit = 1'b0;
        e = pack(1'b0, 4'b0000, 1'b0, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL simul_hit_on_expiry: got %h expected %h", obs(), e);
        end
        hit = 1'b1; tick(); hit = 1'b0;
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL simul_hit_in_gap: got %h expected %h", obs(), e);
        end
        en = 1'b0; tick();
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL simul_en_drop_gap: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_abort_clr();
        logic [14:0] e;
        en = 1'b1;
        tick(); tick(); tick(); tick();
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        m_lfsr = 8'hA5;
        vectors++;
        if (obs() !== 15'd0) begin
            miscompares++;
            $display("FAIL clr_in_show: got %h expected %h", obs(), 15'd0);
        end
        tick(); tick(); tick(); tick();
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd0, 1'b0);
        vectors++;
        if (obs() !== e || lane !== 4'b0100) begin
            miscompares++;
            $display("FAIL clr_restart_lane: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_abort_en();
        logic [14:0] e;
        tick();
        hit = 1'b1; tick(); hit = 1'b0;
        tick(); tick(); tick();
        tick();
        m_lfsr = lfsr_step(m_lfsr);
        e = pack(1'b1, lane_of(m_lfsr), 1'b0, 8'd1, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL en_abort_prompt: got %h expected %h", obs(), e);
        end
        tick();
        en = 1'b0;
        e = pack(1'b0, 4'b0000, 1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL en_abort_idle c%0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    // Each round is replayed as a timeline: a 4-cycle gap, then a window of
    // up to 8 cycles closed by a hit or a miss, ROUND_LEN times, then DONE.
    task automatic test_random_rounds();
        logic [14:0] e;
        logic [7:0]  s;
        int          h;
        for (int r = 0; r < 8; r++) begin
            s = 8'd0;
            en = 1'b1;
            hit = 1'($urandom_range(0, 1));
            tick(); hit = 1'b0;
            for (int p = 0; p <= 3; p++) begin
                for (int g = 1; g < 4; g++) begin
                    hit = 1'($urandom_range(0, 1));
                    tick(); hit = 1'b0;
                    e = pack(1'b0, 4'b0000, 1'b0, s, 1'b0);
                    vectors++;
                    if (obs() !== e) begin
                        miscompares++;
                        $display("FAIL rnd_gap r%0d p%0d g%0d: got %h expected %h", r, p, g, obs(), e);
                    end
                end
                hit = 1'($urandom_range(0, 1));
                tick(); hit = 1'b0;
                if (p == 3) begin
                    e = pack(1'b0, 4'b0000, 1'b0, s, 1'b1);
                end else begin
                    m_lfsr = lfsr_step(m_lfsr);
                    e = pack(1'b1, lane_of(m_lfsr), 1'b0, s, 1'b0);
                end
                vectors++;
                if (obs() !== e) begin
                    miscompares++;
                    $display("FAIL rnd_beat_end r%0d p%0d: got %h expected %h", r, p, obs(), e);
                end
                if (p == 3) break;
                h = int'($urandom_range(1, 10));
                for (int j = 1; j <= 8; j++) begin
                    hit = (j == h);
                    tick(); hit = 1'b0;
                    if (j == h) begin
                        if (s != 8'hFF) s = s + 8'd1;
                        e = pack(1'b0, 4'b0000, 1'b0, s, 1'b0);
                    end else if (j == 8) begin
                        e = pack(1'b0, 4'b0000, 1'b1, s, 1'b0);
                    end else begin
                        e = pack(1'b1, lane_of(m_lfsr), 1'b0, s, 1'b0);
                    end
                    vectors++;
                    if (obs() !== e) begin
                        miscompares++;
                        $display("FAIL rnd_window r%0d p%0d j%0d: got %h expected %h", r, p, j, obs(), e);
                    end
                    if (j == h) break;
                end
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                hit = 1'($urandom_range(0, 1));
                tick(); hit = 1'b0;
                e = pack(1'b0, 4'b0000, 1'b0, s, 1'b1);
                vectors++;
                if (obs() !== e) begin
                    miscompares++;
                    $display("FAIL rnd_done_hold r%0d: got %h expected %h", r, obs(), e);
                end
            end
            en = 1'b0; tick();
            e = pack(1'b0, 4'b0000, 1'b0, s, 1'b0);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL rnd_release r%0d: got %h expected %h", r, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_path();
        test_miss_path();
        test_round_end();
        test_simultaneous();
        test_abort_clr();
        test_abort_en();
        test_random_rounds();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
